calc_sequencer: RTL and testbench

Command sequencer between the host/middleware command stream and the accumulator ALU. It buffers (opcode, P, Q) commands in a small FIFO and issues them to the ALU one at a time. It waits the ALU register latency, then captures result and error code. Each result is returned on a valid/ready response channel tagged with a sequence number, and errors are handled by flushing the queue.

---
 rtl/calc_sequencer.sv | 159 +++++++++++++++
 tb/tb_calc_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: queues ALU commands, issues them one at a time and returns tagged results
module calc_sequencer #(
   parameter int DEPTH = 4,
   parameter int ALU_LAT = 1,
   parameter logic [3:0] NOP_OP = 4'b0000,
   parameter logic [3:0] RST_OP = 4'b1100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [31:0] cmd_p,
   input  logic [31:0] cmd_q,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_error,
   output logic [3:0]  rsp_tag,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_p,
   output logic [31:0] alu_q,
   input  logic [31:0] alu_result,
   input  logic [1:0]  alu_error,
   output logic        busy,
   output logic        err_sticky,
   input  logic        clr_err,
   output logic [7:0]  drop_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_ISSUE = 3'd2,
                          S_CAP = 3'd3, S_RESP = 3'd4, S_ERR = 3'd5;
   logic [2:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [67:0]   mem_q [DEPTH];
   logic [3:0]    alu_op_q, alu_op_d, rsp_tag_q, rsp_tag_d, tag_q, tag_d;
   logic [31:0]   alu_p_q, alu_p_d, alu_q_q, alu_q_d, rsp_result_q, rsp_result_d;
   logic [1:0]    rsp_error_q, rsp_error_d;
   logic          rsp_valid_q, rsp_valid_d, err_sticky_q, err_sticky_d;
   logic [7:0]    drop_q, drop_d;
   logic [8:0]    drop_sum;
   logic          full, push, pop, flush;
   assign full       = count_q == CW'(DEPTH);
   assign cmd_ready  = !full && state_q != S_INIT && state_q != S_ERR;
   assign push       = cmd_valid && cmd_ready;
   assign busy       = count_q != '0 || state_q != S_IDLE;
   assign alu_op     = alu_op_q;
   assign alu_p      = alu_p_q;
   assign alu_q      = alu_q_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_error  = rsp_error_q;
   assign rsp_tag    = rsp_tag_q;
   assign err_sticky = err_sticky_q;
   assign drop_count = drop_q;
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_op_d     = alu_op_q;
      alu_p_d      = alu_p_q;
      alu_q_d      = alu_q_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      rsp_tag_d    = rsp_tag_q;
      tag_d        = tag_q;
      err_sticky_d = err_sticky_q;
      pop          = 1'b0;
      flush        = 1'b0;
      case (state_q)
         S_INIT: begin
            alu_op_d = (cnt_q == 8'(ALU_LAT + 1)) ? NOP_OP : RST_OP;
            state_d  = (cnt_q == 8'(ALU_LAT + 1)) ? S_IDLE : S_INIT;
            cnt_d    = (cnt_q == 8'(ALU_LAT + 1)) ? 8'd0 : cnt_q + 8'd1;
         end
         S_IDLE: begin
            alu_op_d = NOP_OP;
            if (count_q != '0) begin
               pop = 1'b1;
               {alu_op_d, alu_p_d, alu_q_d} = mem_q[rd_ptr_q];
               cnt_d   = 8'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = (cnt_q == 8'(ALU_LAT - 1)) ? S_CAP : S_ISSUE;
            cnt_d   = (cnt_q == 8'(ALU_LAT - 1)) ? 8'd0 : cnt_q + 8'd1;
         end
         S_CAP: begin
            alu_op_d     = NOP_OP;
            rsp_result_d = alu_result;
            rsp_error_d  = alu_error;
            rsp_tag_d    = tag_q;
            rsp_valid_d  = 1'b1;
            tag_d        = tag_q + 4'd1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d  = 1'b0;
               flush        = rsp_error_q != 2'b00;
               err_sticky_d = err_sticky_q || flush;
               state_d      = flush ? S_ERR : S_IDLE;
            end
         end
         S_ERR: begin
            err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
            state_d      = clr_err ? S_IDLE : S_ERR;
         end
         default: state_d = S_INIT;
      endcase
      // a command pushed on the flush edge is dropped along with the queue
      drop_sum = {1'b0, drop_q} + 9'(count_q) + 9'(push);
      drop_d   = flush ? (drop_sum[8] ? 8'hFF : drop_sum[7:0]) : drop_q;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = flush ? wr_ptr_d : rd_ptr_q + PW'(pop);
      count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_p, cmd_q};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         alu_op_q     <= NOP_OP;
         alu_p_q      <= '0;
         alu_q_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_error_q  <= '0;
         rsp_tag_q    <= '0;
         tag_q        <= '0;
         err_sticky_q <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         alu_op_q     <= alu_op_d;
         alu_p_q      <= alu_p_d;
         alu_q_q      <= alu_q_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
         rsp_tag_q    <= rsp_tag_d;
         tag_q        <= tag_d;
         err_sticky_q <= err_sticky_d;
         drop_q       <= drop_d;
      end
   end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed vectors and corner sequences against a P+Q stub ALU
module tb_calc_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1, clr_err = 1'b0;
   logic [3:0]  cmd_op = '0, rsp_tag, alu_op;
   logic [31:0] cmd_p = '0, cmd_q = '0, rsp_result, alu_p, alu_q, alu_result = '0;
   logic [1:0]  rsp_error, alu_error = '0;
   logic        busy, err_sticky;
   logic [7:0]  drop_count;
   int          pass_cnt = 0, total_cnt = 0;
   logic [3:0]  exp_tag = '0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] p;
      logic [31:0] q;
      logic [31:0] res;
   } vec_t;
   vec_t vecs [5];

   calc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_p(cmd_p), .cmd_q(cmd_q), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
      .rsp_tag(rsp_tag), .alu_op(alu_op), .alu_p(alu_p), .alu_q(alu_q),
      .alu_result(alu_result), .alu_error(alu_error), .busy(busy),
      .err_sticky(err_sticky), .clr_err(clr_err), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      alu_result <= alu_p + alu_q;
      alu_error  <= (alu_p == 32'hDEADBEEF) ? 2'b10 : 2'b00;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_p = p; cmd_q = q;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      check("cmd_accept", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string name, input logic [31:0] res, input logic [1:0] err);
      int n = 0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      check({name, "_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_result"}, rsp_result, res);
      check({name, "_error"}, 32'(rsp_error), 32'(err));
      check({name, "_tag"}, 32'(rsp_tag), 32'(exp_tag));
      exp_tag++;
      tick();
   endtask

   task automatic init_seq(input string name);
      tick();
      check({name, "_op1"}, 32'(alu_op), 32'hC);
      check({name, "_rdy1"}, 32'(cmd_ready), 32'd0);
      tick();
      check({name, "_op2"}, 32'(alu_op), 32'hC);
      tick();
      check({name, "_op3"}, 32'(alu_op), 32'h0);
      check({name, "_rdy3"}, 32'(cmd_ready), 32'd1);
      check({name, "_busy3"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic seen;
      vecs[0] = '{4'h1, 32'd0, 32'd0, 32'd0};
      vecs[1] = '{4'h3, 32'hFFFFFFFF, 32'd1, 32'd0};
      vecs[2] = '{4'h5, 32'h80000000, 32'h80000000, 32'd0};
      vecs[3] = '{4'h7, 32'h12345678, 32'h11111111, 32'h23456789};
      vecs[4] = '{4'h2, 32'd1000, 32'd24, 32'd1024};
      // reset held with random inputs
      repeat (4) begin
         cmd_valid = 1'($urandom); cmd_op = 4'($urandom); cmd_p = $urandom; cmd_q = $urandom;
         rsp_ready = 1'($urandom); clr_err = 1'($urandom);
         tick();
      end
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_alu_p", alu_p, 32'd0);
      check("rst_alu_q", alu_q, 32'd0);
      check("rst_err_sticky", 32'(err_sticky), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      cmd_valid = 1'b0; clr_err = 1'b0; rsp_ready = 1'b1;
      rst_n = 1'b1;
      init_seq("init");
      // single command timing
      push_cmd(4'b0010, 32'd3141, 32'd2);
      check("single_busy", 32'(busy), 32'd1);
      tick();
      tick();
      check("single_n2_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("single_n3_valid", 32'(rsp_valid), 32'd1);
      check("single_result", rsp_result, 32'd3143);
      check("single_error", 32'(rsp_error), 32'd0);
      check("single_tag", 32'(rsp_tag), 32'd0);
      tick();
      check("single_n4_valid", 32'(rsp_valid), 32'd0);
      check("single_idle_busy", 32'(busy), 32'd0);
      exp_tag = 4'd1;
      for (int i = 0; i < 5; i++) begin
         push_cmd(vecs[i].op, vecs[i].p, vecs[i].q);
         get_rsp("vec", vecs[i].res, 2'b00);
      end
      // backpressure and full FIFO
      rsp_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push_cmd(4'h1, 32'(i), 32'd10);
      check("bp_full_ready", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_result", rsp_result, 32'd11);
         check("bp_hold_tag", 32'(rsp_tag), 32'(exp_tag));
         tick();
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) get_rsp("bp", 32'(11 + i), 2'b00);
      // tag wrap
      for (int i = 0; i < 17; i++) begin
         push_cmd(4'h3, 32'(i), 32'd100);
         get_rsp("wrap", 32'(i + 100), 2'b00);
      end
      // error flush
      push_cmd(4'h1, 32'd7, 32'd0);
      push_cmd(4'h1, 32'hDEADBEEF, 32'd0);
      push_cmd(4'h1, 32'd9, 32'd0);
      push_cmd(4'h1, 32'd9, 32'd0);
      get_rsp("err_ok", 32'd7, 2'b00);
      get_rsp("err_bad", 32'hDEADBEEF, 2'b10);
      check("err_sticky", 32'(err_sticky), 32'd1);
      check("err_drop", 32'(drop_count), 32'd2);
      check("err_ready", 32'(cmd_ready), 32'd0);
      check("err_busy", 32'(busy), 32'd1);
      cmd_valid = 1'b1; cmd_p = 32'd55;
      repeat (3) tick();
      check("err_still_blocked", 32'(cmd_ready), 32'd0);
      check("err_no_rsp", 32'(rsp_valid), 32'd0);
      cmd_valid = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_ready", 32'(cmd_ready), 32'd1);
      check("clr_sticky", 32'(err_sticky), 32'd0);
      check("clr_drop", 32'(drop_count), 32'd2);
      check("clr_busy", 32'(busy), 32'd0);
      push_cmd(4'h1, 32'd20, 32'd1);
      get_rsp("after_flush", 32'd21, 2'b00);
      // reset during ISSUE
      push_cmd(4'h1, 32'd5, 32'd5);
      tick();
      check("mid_alu_p", alu_p, 32'd5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_alu_op", 32'(alu_op), 32'd0);
      check("mid_rst_alu_p", alu_p, 32'd0);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
      init_seq("reinit");
      seen = 1'b0;
      repeat (5) begin tick(); seen = seen | rsp_valid; end
      check("mid_no_rsp", 32'(seen), 32'd0);
      exp_tag = '0;
      push_cmd(4'h2, 32'd1, 32'd2);
      get_rsp("post_reset", 32'd3, 2'b00);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
